// File: rtl/scr1_imem_arb.sv
// Two-master arbiter for the shared imem port with an in-order owner FIFO.
// Define SCR1_IMEM_ARB_RR_EN for round-robin contention; default is m0 priority.
module scr1_imem_arb #(
  parameter int ARB_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_req_ack,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_resp,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_req_ack,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_resp,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_resp,
  output logic        arb_busy,
  output logic        arb_err
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] DEPTH = 3'(ARB_OUTST);
  localparam logic [1:0] LAST  = 2'(ARB_OUTST - 1);

  state_t      state;
  logic        hold_id;
  logic        sel;
  logic        grant;
  logic        held_req;
  logic        full;
  logic        hs;
  logic        resp_v;
  logic        spurious;
  logic        head;
  logic [3:0]  fifo;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef SCR1_IMEM_ARB_RR_EN
  // Remembers the last granted master; the other one wins next contention.
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (hs) begin
      last <= grant;
    end
  end

  assign sel = (m0_req & m1_req) ? ~last : ~m0_req;
`else
  assign sel = ~m0_req;
`endif

  assign full     = (count == DEPTH);
  assign held_req = hold_id ? m1_req : m0_req;
  assign grant    = (state == HOLD) ? hold_id : sel;
  assign imem_req = ~rst & ~full &
                    ((state == HOLD) ? held_req : (m0_req | m1_req));
  assign imem_addr = grant ? m1_addr : m0_addr;
  assign hs        = imem_req & imem_req_ack;

  assign m0_req_ack = hs & ~grant;
  assign m1_req_ack = hs & grant;

  assign head     = fifo[rd_ptr];
  assign resp_v   = ~rst & (imem_resp != 2'b00) & (count != 3'd0);
  assign spurious = (imem_resp != 2'b00) & (count == 3'd0);

  assign m0_resp  = (resp_v & ~head) ? imem_resp : 2'b00;
  assign m1_resp  = (resp_v & head) ? imem_resp : 2'b00;
  assign m0_rdata = (resp_v & ~head) ? imem_rdata : 32'h0;
  assign m1_rdata = (resp_v & head) ? imem_rdata : 32'h0;

  assign arb_busy = (count != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hold_id <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (imem_req & ~imem_req_ack) begin
            state   <= HOLD;
            hold_id <= sel;
          end
        end
        HOLD: begin
          if (~held_req | imem_req_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (hs) begin
        fifo[wr_ptr] <= grant;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (resp_v) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({hs, resp_v})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_err <= 1'b0;
    end else if (spurious) begin
      arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scr1_imem_arb.sv
// Directed bench for scr1_imem_arb: single read, contention, hold,
// abandon, full, error response, spurious response and reset mid-flight.
module tb_scr1_imem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_req_ack, m1_req_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_resp, m1_resp;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        arb_busy, arb_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_g [4];

  scr1_imem_arb #(.ARB_OUTST(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_req_ack(m0_req_ack),
    .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_req_ack(m1_req_ack),
    .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_req_ack(imem_req_ack), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .arb_busy(arb_busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_req = 0; m1_req = 0; imem_req_ack = 0;
    imem_resp = 2'b00; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
`ifdef SCR1_IMEM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    rst = 1; idle_in();
    m0_addr = 32'h100; m1_addr = 32'h104;
    tick();
    // reset forces outputs quiet even with live inputs
    m0_req = 1; imem_req_ack = 1; imem_resp = 2'b01;
    imem_rdata = 32'h1234;
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_m0_ack", m0_req_ack, 0);
    chk("rst_m0_resp", m0_resp, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    tick();
    rst = 0; idle_in();
    @(negedge clk);
    chk("rst_busy", arb_busy, 0);
    chk("rst_err", arb_err, 0);
    tick();

    // single read
    m0_req = 1; m0_addr = 32'h200; imem_req_ack = 1;
    @(negedge clk);
    chk("sr_req", imem_req, 1);
    chk("sr_addr", imem_addr, 32'h200);
    chk("sr_m0_ack", m0_req_ack, 1);
    chk("sr_m1_ack", m1_req_ack, 0);
    tick();
    idle_in();
    @(negedge clk);
    chk("sr_busy1", arb_busy, 1);
    chk("sr_resp1", m0_resp, 0);
    tick();
    imem_resp = 2'b01; imem_rdata = 32'h00C54533;
    @(negedge clk);
    chk("sr_m0_resp", m0_resp, 2'b01);
    chk("sr_m0_rdata", m0_rdata, 32'h00C54533);
    chk("sr_m1_resp", m1_resp, 0);
    chk("sr_m1_rdata", m1_rdata, 0);
    chk("sr_busy2", arb_busy, 1);
    tick();
    idle_in();
    @(negedge clk);
    chk("sr_busy3", arb_busy, 0);
    tick();

    // contention, acked every cycle, responses one cycle behind
    do_reset();
    m0_addr = 32'h100; m1_addr = 32'h104;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m1_req = 1; imem_req_ack = 1;
      imem_resp = (i > 0) ? 2'b01 : 2'b00;
      imem_rdata = 32'hA0 + 32'(i);
      @(negedge clk);
      chk($sformatf("ct_m0_ack%0d", i), m0_req_ack, {31'b0, ~exp_g[i]});
      chk($sformatf("ct_m1_ack%0d", i), m1_req_ack, {31'b0, exp_g[i]});
      chk($sformatf("ct_addr%0d", i), imem_addr,
          exp_g[i] ? 32'h104 : 32'h100);
      if (i > 0) begin
        chk($sformatf("ct_m1_resp%0d", i), m1_resp,
            exp_g[i-1] ? 32'h1 : 32'h0);
        chk($sformatf("ct_m0_resp%0d", i), m0_resp,
            exp_g[i-1] ? 32'h0 : 32'h1);
      end
      tick();
    end
    idle_in(); imem_resp = 2'b01; imem_rdata = 32'hA4;
    @(negedge clk);
    chk("ct_busy", arb_busy, 1);
    chk("ct_last_m1", m1_resp, exp_g[3] ? 32'h1 : 32'h0);
    chk("ct_last_rd", exp_g[3] ? m1_rdata : m0_rdata, 32'hA4);
    tick();
    idle_in();
    @(negedge clk);
    chk("ct_idle", arb_busy, 0);
    tick();

    // hold: m1 raised while m0 waits for ack
    do_reset();
    m0_addr = 32'h300; m1_addr = 32'h304;
    m0_req = 1;
    @(negedge clk);
    chk("hd_addr0", imem_addr, 32'h300);
    chk("hd_ack0", m0_req_ack, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      m1_req = 1;
      @(negedge clk);
      chk($sformatf("hd_addr%0d", i + 1), imem_addr, 32'h300);
      chk($sformatf("hd_m1ack%0d", i + 1), m1_req_ack, 0);
      tick();
    end
    imem_req_ack = 1;
    @(negedge clk);
    chk("hd_m0_ack", m0_req_ack, 1);
    chk("hd_m1_ack", m1_req_ack, 0);
    chk("hd_addr3", imem_addr, 32'h300);
    tick();

    // abandon: held m1 drops its request
    do_reset();
    m1_req = 1;
    tick();
    m1_req = 0; m0_req = 1; imem_req_ack = 1;
    @(negedge clk);
    chk("ab_req", imem_req, 0);
    chk("ab_m0_ack", m0_req_ack, 0);
    tick();
    @(negedge clk);
    chk("ab_m0_ack2", m0_req_ack, 1);
    chk("ab_busy0", arb_busy, 0);
    tick();

    // full with two outstanding, then an error response
    do_reset();
    m0_addr = 32'h400; m1_addr = 32'h404;
    m0_req = 1; imem_req_ack = 1;
    tick();
    m0_req = 0; m1_req = 1;
    @(negedge clk);
    chk("fl_m1_ack", m1_req_ack, 1);
    tick();
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    chk("fl_req", imem_req, 0);
    chk("fl_m0_ack", m0_req_ack, 0);
    chk("fl_m1_ack2", m1_req_ack, 0);
    chk("fl_busy", arb_busy, 1);
    tick();
    imem_resp = 2'b01; imem_rdata = 32'h11111111;
    @(negedge clk);
    chk("fl_m0_resp", m0_resp, 2'b01);
    chk("fl_m0_rdata", m0_rdata, 32'h11111111);
    chk("fl_m1_resp", m1_resp, 0);
    chk("fl_req_pop", imem_req, 0);
    tick();
    imem_resp = 2'b00;
    @(negedge clk);
    chk("fl_reassert", imem_req, 1);
    chk("fl_m0_ack3", m0_req_ack, 1);
    tick();
    idle_in(); imem_resp = 2'b10; imem_rdata = 32'hDEAD;
    @(negedge clk);
    chk("er_m1_resp", m1_resp, 2'b10);
    chk("er_m1_rdata", m1_rdata, 32'hDEAD);
    chk("er_m0_resp", m0_resp, 0);
    tick();
    idle_in(); imem_resp = 2'b10; imem_rdata = 32'hBEEF;
    @(negedge clk);
    chk("er_m0_resp2", m0_resp, 2'b10);
    chk("er_err", arb_err, 0);
    tick();

    // spurious response
    do_reset();
    imem_resp = 2'b01; imem_rdata = 32'h55;
    @(negedge clk);
    chk("sp_m0", m0_resp, 0);
    chk("sp_m1", m1_resp, 0);
    chk("sp_err0", arb_err, 0);
    tick();
    idle_in();
    @(negedge clk);
    chk("sp_err1", arb_err, 1);
    tick();
    @(negedge clk);
    chk("sp_err2", arb_err, 1);
    tick();

    // reset with one transaction in flight
    do_reset();
    m0_req = 1; imem_req_ack = 1;
    tick();
    idle_in(); rst = 1;
    @(negedge clk);
    chk("rm_req", imem_req, 0);
    tick();
    rst = 0; imem_resp = 2'b10; imem_rdata = 32'h77;
    @(negedge clk);
    chk("rm_busy", arb_busy, 0);
    chk("rm_err0", arb_err, 0);
    chk("rm_m0", m0_resp, 0);
    chk("rm_m1", m1_resp, 0);
    tick();
    idle_in();
    @(negedge clk);
    chk("rm_err1", arb_err, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
